// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl
// Purpose: PWM generator whose duty level fades from its current value toward
//          a commanded target, one level step every cmd_rate PWM periods.
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   rst        - asynchronous active-high reset
//   cmd_valid  - fade command offered
//   cmd_ready  - high while the block can accept a command (IDLE only)
//   cmd_target - requested final duty level (clamped to MAX_LEVEL)
//   cmd_rate   - PWM periods per one-level step (0 treated as 1)
//   level      - current duty level
//   pwm_out    - registered PWM waveform, duty = level / MAX_LEVEL
//   busy       - high while a fade is in progress
//   done       - one-cycle pulse when a fade completes
module pwm_fade_ctrl #(
  parameter int MAX_LEVEL  = 10,
  parameter int INIT_LEVEL = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_target,
  input  logic [7:0] cmd_rate,
  output logic [3:0] level,
  output logic       pwm_out,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] MAX_L  = 4'(MAX_LEVEL);
  localparam logic [3:0] INIT_L = 4'(INIT_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_DONE
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic [3:0] r_cnt;
  logic [3:0] r_level;
  logic [3:0] r_target;
  logic [7:0] r_rate;
  logic [7:0] r_rc;
  logic       r_pwm;

  logic       w_boundary;
  logic       w_accept;
  logic       w_step;
  logic [3:0] w_cmd_target;
  logic [7:0] w_cmd_rate;
  logic [3:0] w_level_step;

  // Last cycle of each PWM period; the only cycle on which level may move.
  assign w_boundary   = (r_cnt == MAX_L);
  assign w_accept     = (r_state == ST_IDLE) && cmd_valid;
  assign w_cmd_target = (cmd_target > MAX_L) ? MAX_L : cmd_target;
  assign w_cmd_rate   = (cmd_rate == 8'd0) ? 8'd1 : cmd_rate;

  // A step happens when the rate counter has seen 'rate' boundaries.
  assign w_step = (r_state == ST_RAMP) && w_boundary && (r_rc == (r_rate - 8'd1));

  // One level toward target; the equal case cannot occur in RAMP but is held
  // anyway so level can never leave the 0..MAX_LEVEL range.
  assign w_level_step = (r_target > r_level) ? (r_level + 4'd1) :
                        (r_target < r_level) ? (r_level - 4'd1) : r_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_next = (w_cmd_target == r_level) ? ST_DONE : ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (w_step && (w_level_step == r_target)) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= 4'd1;
      r_level  <= INIT_L;
      r_target <= INIT_L;
      r_rate   <= 8'd1;
      r_rc     <= 8'd0;
      r_pwm    <= 1'b0;
    end else begin
      // Period counter runs 1..MAX_LEVEL regardless of FSM state.
      r_cnt <= w_boundary ? 4'd1 : (r_cnt + 4'd1);
      r_pwm <= (r_cnt <= r_level);

      if (w_accept) begin
        r_target <= w_cmd_target;
        r_rate   <= w_cmd_rate;
        r_rc     <= 8'd0;
      end else if ((r_state == ST_RAMP) && w_boundary) begin
        if (w_step) begin
          r_level <= w_level_step;
          r_rc    <= 8'd0;
        end else begin
          r_rc <= r_rc + 8'd1;
        end
      end
    end
  end

  assign level     = r_level;
  assign pwm_out   = r_pwm;
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_RAMP);
  assign done      = (r_state == ST_DONE);

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl
// Purpose: directed self-checking bench for pwm_fade_ctrl (MAX_LEVEL=10,
//          INIT_LEVEL=5). Walks reset, idle duty, ramp up, clamp with zero
//          rate, null fade, ignored command during RAMP and reset mid-ramp.
module tb_pwm_fade_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_target;
  logic [7:0] cmd_rate;
  logic [3:0] level;
  logic       pwm_out;
  logic       busy;
  logic       done;

  int n_checks;
  int n_fail;
  int cyc;

  pwm_fade_ctrl #(
    .MAX_LEVEL (10),
    .INIT_LEVEL(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_target(cmd_target),
    .cmd_rate  (cmd_rate),
    .level     (level),
    .pwm_out   (pwm_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int observed, input int expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [3:0] tgt, input logic [7:0] rate);
    cmd_valid  = 1'b1;
    cmd_target = tgt;
    cmd_rate   = rate;
    tick();
    cmd_valid  = 1'b0;
    $display("cmd target=%0d rate=%0d accepted at cyc=%0d level=%0d busy=%0b done=%0b",
             tgt, rate, cyc, level, busy, done);
  endtask

  // Run until done, checking each level change is +/-1 and spaced by gap.
  task automatic ramp_watch(input string tag, input int dir, input int gap,
                            output int n_steps, output int bad_busy);
    int prev;
    int last;
    prev     = int'(level);
    last     = -1;
    n_steps  = 0;
    bad_busy = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      if (int'(level) != prev) begin
        chk({tag, "_step_val"}, int'(level), prev + dir);
        if (last >= 0) chk({tag, "_step_gap"}, cyc - last, gap);
        $display("%s level %0d -> %0d at cyc=%0d", tag, prev, level, cyc);
        last = cyc;
        prev = int'(level);
        n_steps++;
      end
      if (!done && !busy) bad_busy++;
    end
    chk({tag, "_done_seen"}, int'(done), 1);
  endtask

  logic [9:0] idle_pat;
  int         n_steps;
  int         bad_busy;
  int         n_high;
  int         n_done;

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    rst        = 1'b0;
    cmd_valid  = 1'b0;
    cmd_target = 4'd0;
    cmd_rate   = 8'd0;

    // Reset takes effect with no clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_level", int'(level), 5);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    $display("reset level=%0d pwm=%0b ready=%0b busy=%0b done=%0b",
             level, pwm_out, cmd_ready, busy, done);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Idle duty: high on clocks 1..5 of every 10 after release.
    idle_pat = 10'b0000011111;
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("idle_pwm", int'(pwm_out), int'(idle_pat[n % 10]));
    end
    chk("idle_level", int'(level), 5);
    $display("idle duty checked over 20 cycles level=%0d", level);

    // Ramp 5 -> 8, one step per 2 periods (20 clocks).
    send(4'd8, 8'd2);
    chk("up_busy_acc", int'(busy), 1);
    chk("up_ready_acc", int'(cmd_ready), 0);
    ramp_watch("up", 1, 20, n_steps, bad_busy);
    chk("up_level_end", int'(level), 8);
    chk("up_n_steps", n_steps, 3);
    chk("up_busy_gaps", bad_busy, 0);
    tick();
    chk("up_done_pulse", int'(done), 0);
    chk("up_ready_after", int'(cmd_ready), 1);
    chk("up_level_hold", int'(level), 8);

    // Target 15 clamps to 10, rate 0 acts as 1.
    send(4'd15, 8'd0);
    chk("clamp_busy_acc", int'(busy), 1);
    ramp_watch("clamp", 1, 10, n_steps, bad_busy);
    chk("clamp_level_end", int'(level), 10);
    chk("clamp_n_steps", n_steps, 2);
    chk("clamp_busy_gaps", bad_busy, 0);
    tick();
    chk("clamp_ready_after", int'(cmd_ready), 1);
    n_high = 0;
    for (int n = 0; n < 20; n++) begin
      if (pwm_out === 1'b1) n_high++;
      tick();
    end
    chk("clamp_pwm_full", n_high, 20);
    $display("full duty checked over 20 cycles level=%0d", level);

    // Null fade: target equals current level.
    send(4'd10, 8'd3);
    chk("null_done", int'(done), 1);
    chk("null_busy", int'(busy), 0);
    chk("null_level", int'(level), 10);
    tick();
    chk("null_done_clr", int'(done), 0);
    chk("null_ready", int'(cmd_ready), 1);
    chk("null_busy_after", int'(busy), 0);

    // Ramp toward 0; a command offered mid-ramp must be ignored.
    send(4'd0, 8'd1);
    chk("down_busy_acc", int'(busy), 1);
    tick();
    send(4'd10, 8'd5);
    chk("ignore_busy", int'(busy), 1);
    for (int i = 0; i < 60 && level > 4'd8; i++) tick();
    chk("down_level_8", int'(level), 8);
    chk("down_still_busy", int'(busy), 1);
    chk("down_ready_low", int'(cmd_ready), 0);

    // Asynchronous reset mid-ramp, checked before the next edge.
    rst = 1'b1;
    #1;
    chk("mid_rst_level", int'(level), 5);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_ready", int'(cmd_ready), 1);
    chk("mid_rst_pwm", int'(pwm_out), 0);
    $display("mid-ramp reset level=%0d busy=%0b done=%0b", level, busy, done);
    #1 rst = 1'b0;

    n_high = 0;
    n_done = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (n == 0) chk("post_rst_first_pwm", int'(pwm_out), 1);
      if (pwm_out === 1'b1) n_high++;
      if (done === 1'b1) n_done++;
    end
    chk("post_rst_duty", n_high, 5);
    chk("post_rst_no_done", n_done, 0);
    chk("post_rst_level", int'(level), 5);
    chk("post_rst_idle", int'(cmd_ready), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEVEL, default 10, giving PWM period length in clocks and the top duty level.
REQ-002 SHALL have parameter INIT_LEVEL, default 5, giving the duty level loaded at reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: fade command offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit: block can accept a command.
REQ-007 SHALL have port cmd_target, input, 4 bits: requested final duty level.
REQ-008 SHALL have port cmd_rate, input, 8 bits: PWM periods per one-level step.
REQ-009 SHALL have port level, output, 4 bits: current duty level.
REQ-010 SHALL have port pwm_out, output, 1 bit: registered PWM waveform.
REQ-011 SHALL have port busy, output, 1 bit: fade in progress.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse on fade completion.

Function
REQ-013 SHALL keep a period counter cnt stepping 1,2,...,MAX_LEVEL, then back to 1; the period boundary is the cycle with cnt==MAX_LEVEL.
REQ-014 SHALL register pwm_out <= (cnt <= level) every clock, so pwm_out lags cnt/level by one cycle; duty = level/MAX_LEVEL, level 0 gives constant 0, level MAX_LEVEL constant 1.
REQ-015 SHALL implement FSM states IDLE, RAMP, DONE.
REQ-016 SHALL drive cmd_ready=1 only in IDLE; busy=1 only in RAMP; done=1 only in DONE.
REQ-017 SHALL accept a command on a clock where cmd_valid && cmd_ready, latching target=min(cmd_target, MAX_LEVEL) and rate=max(cmd_rate,1).
REQ-018 SHALL on acceptance go to DONE if target==level, otherwise go to RAMP with rate counter rc cleared to 0.
REQ-019 SHALL in RAMP, on each period boundary: if rc==rate-1, step level one toward target and clear rc; else rc<=rc+1.
REQ-020 SHALL change level only on a period boundary, never mid-period.
REQ-021 SHALL go from RAMP to DONE on the boundary where the stepped level equals target.
REQ-022 SHALL stay in DONE exactly one cycle, then return to IDLE; a new command is acceptable on the following cycle.
REQ-023 SHALL ignore cmd_valid, cmd_target and cmd_rate while not in IDLE, with no queuing.
REQ-024 SHALL keep cnt free-running in every state, independent of the FSM.
REQ-025 SHALL hold level constant in IDLE and DONE.
REQ-026 SHALL never let level go below 0 or above MAX_LEVEL.

Reset
REQ-027 SHALL while rst=1 force state=IDLE, level=INIT_LEVEL, cnt=1, rc=0, target=INIT_LEVEL, rate=1, pwm_out=0, done=0, busy=0, cmd_ready=1.
REQ-028 SHALL, when rst asserts mid-RAMP, discard the fade immediately (asynchronously) with no done pulse.
REQ-029 SHALL resume normal counting on the first clock after rst deasserts.

Verification
REQ-030 SHALL cover reset: assert rst -> level=5, pwm_out=0, cmd_ready=1, busy=0, done=0, without any clock edge.
REQ-031 SHALL cover idle duty: after reset with no command -> pwm_out high 5 of every 10 clocks, repeating.
REQ-032 SHALL cover ramp up: command target=8, rate=2 -> level steps 5->6->7->8, one step every 20 clocks, busy high throughout, exactly one done pulse, cmd_ready=1 the cycle after done.
REQ-033 SHALL cover clamp and zero rate: command target=15, rate=0 -> target treated as 10, one step per period, level reaches 10, pwm_out then constant 1.
REQ-034 SHALL cover null fade: command target=level -> done=1 on the cycle after acceptance, level unchanged, busy never high.
REQ-035 SHALL cover busy and reset mid-ramp: cmd_valid pulsed during RAMP -> ignored; rst pulsed during ramp toward 0 -> level=5, state IDLE, no done pulse.
